// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with an oversampled, synchronized input and
// a small receive FIFO presented through a valid/ready handshake.
//
// Ports:
//   clk         system clock, everything on the rising edge
//   rst         asynchronous active-high reset
//   rx_pin      asynchronous serial line, idle high
//   rx_data     FIFO head byte (zero while the FIFO is empty)
//   rx_valid    FIFO holds at least one byte
//   rx_ready    consumer takes the head byte when rx_valid & rx_ready
//   fifo_count  number of bytes held, 0..FIFO_DEPTH
//   frame_err   one-cycle pulse when a stop bit is sampled low
//   overrun     sticky flag: a byte was dropped because the FIFO was full
//   clr_err     synchronous clear of overrun (a new overrun wins)
module uart_rx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rx_pin,
  output logic [DATA_BITS-1:0]            rx_data,
  output logic                            rx_valid,
  input  logic                            rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            frame_err,
  output logic                            overrun,
  input  logic                            clr_err
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t               state;
  logic                 sync1;
  logic                 rxs;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [NW-1:0]        count;

  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 wr_en;

  // Two-flop synchronizer; flops reset to the idle (high) line level so a
  // reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rx_pin;
      rxs   <= sync1;
    end
  end

  // Character framing. cnt counts cycles within the current bit; the start
  // bit is checked half a bit after the edge, then every full bit period
  // lands in the middle of the next bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == CW'(H - 1)) begin
            cnt <= '0;
            if (rxs) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt   <= '0;
            shift <= {rxs, shift[DATA_BITS-1:1]};
            if (bit_idx == BW'(DATA_BITS - 1)) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt <= '0;
            if (rxs) begin
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          // A held-low line (break) must not be mistaken for a new start bit.
          if (rxs) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The push is taken on the stop-sample cycle itself so the byte is
  // visible on the very next cycle.
  assign push  = (state == STOP) && (cnt == CW'(CLKS_PER_BIT - 1)) && rxs;
  assign full  = (count == NW'(FIFO_DEPTH));
  assign pop   = rx_valid && rx_ready;
  assign wr_en = push && (!full || pop);

  // Storage needs no reset: only entries between the pointers are visible.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= shift;
    end
  end

  // Pointer and occupancy bookkeeping. A simultaneous push and pop on a full
  // FIFO writes the slot being vacated, so nothing is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full && !pop) begin
        overrun <= 1'b1;
      end else if (clr_err) begin
        overrun <= 1'b0;
      end
    end
  end

  assign rx_valid   = (count != '0);
  assign rx_data    = rx_valid ? mem[rd_ptr] : '0;
  assign fifo_count = count;

endmodule
